// File: rtl/verifier_sched_pkg.sv
// Shared scheduler definitions for the verifier adder tree:
// field parameters, FSM state encoding, the mod-p adder and the
// round-robin pick helper.
package verifier_sched_pkg;

  // Field: integers mod the Mersenne prime 2^61 - 1
  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_PRIME = 61'h1FFF_FFFF_FFFF_FFFF;

  // Round-robin helper works on a fixed maximum requester count
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

  // Mod-p addition; both operands are assumed already reduced (< p)
  function automatic logic [F_NBITS-1:0] f_add(input logic [F_NBITS-1:0] a,
                                               input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_PRIME}) begin
      s = s - {1'b0, F_PRIME};
    end
    return s[F_NBITS-1:0];
  endfunction

  // Rotating priority: search starts at last+1 and wraps modulo n.
  // Returns last unchanged when no request bit is set.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX-1:0]   req_v,
                                                  input logic [RR_IDX_W-1:0] last,
                                                  input logic [RR_IDX_W:0]   n);
    logic [RR_IDX_W-1:0] pick;
    logic [RR_IDX_W:0]   idx;
    logic                found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = {1'b0, last} + (RR_IDX_W+1)'(i);
      if (idx >= n) begin
        idx = idx - n;
      end
      if (!found && (i <= int'(n)) && req_v[idx[RR_IDX_W-1:0]]) begin
        pick  = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/verifier_adder_tree.sv
// Mod-p reduction of ngates field elements. A single-cycle en pulse
// starts the sum; operands must stay stable until ready_pulse, which
// marks the cycle in which v holds the new result.
module verifier_adder_tree
  import verifier_sched_pkg::*;
#(
  parameter int ngates = 35
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            en,
  input  logic [ngates-1:0][F_NBITS-1:0]  v_parts,
  output logic [F_NBITS-1:0]              v,
  output logic                            ready,
  output logic                            ready_pulse
);

  localparam int CNT_W = $clog2(ngates);

  logic                 running_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [F_NBITS-1:0]   acc_r;
  logic [F_NBITS-1:0]   v_r;
  logic                 ready_pulse_r;

  // Accumulate one operand per cycle and publish the final sum with a pulse
  always_ff @(posedge clk) begin
    if (!rstb) begin
      running_r     <= 1'b0;
      cnt_r         <= '0;
      acc_r         <= '0;
      v_r           <= '0;
      ready_pulse_r <= 1'b0;
    end else begin
      ready_pulse_r <= 1'b0;
      if (en && !running_r) begin
        running_r <= 1'b1;
        cnt_r     <= '0;
        acc_r     <= '0;
      end else if (running_r) begin
        if (cnt_r == CNT_W'(ngates - 1)) begin
          v_r           <= f_add(acc_r, v_parts[cnt_r]);
          ready_pulse_r <= 1'b1;
          running_r     <= 1'b0;
        end else begin
          acc_r <= f_add(acc_r, v_parts[cnt_r]);
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign v           = v_r;
  assign ready       = ~running_r;
  assign ready_pulse = ready_pulse_r;

endmodule

// File: rtl/verifier_adder_tree_sched.sv
// Round-robin scheduler sharing one adder tree among nreq requesters.
// IDLE picks a winner, LAUNCH fires the tree for one cycle, WAIT holds
// the operand mux until the tree reports, DONE pulses the winner's bit.
module verifier_adder_tree_sched
  import verifier_sched_pkg::*;
#(
  parameter int ngates = 35,
  parameter int nreq   = 4
) (
  input  logic                                      clk,
  input  logic                                      rstb,
  input  logic [nreq-1:0]                           req,
  input  logic [nreq-1:0][ngates-1:0][F_NBITS-1:0]  v_parts_in,
  output logic [nreq-1:0]                           grant,
  output logic [nreq-1:0]                           done,
  output logic [F_NBITS-1:0]                        v_out,
  output logic                                      busy
);

  sched_state_e                state_r, state_s;
  logic [nreq-1:0]             grant_r, grant_s;
  logic [nreq-1:0]             done_r, done_s;
  logic [F_NBITS-1:0]          v_out_r, v_out_s;
  logic                        busy_r, busy_s;
  logic                        en_r, en_s;
  logic [RR_IDX_W-1:0]         last_r, last_s;

  logic [RR_IDX_W-1:0]         pick_s;
  logic [nreq-1:0]             pick_oh_s;
  logic [ngates-1:0][F_NBITS-1:0] tree_parts_s;
  logic [F_NBITS-1:0]          tree_v;
  logic                        tree_ready;
  logic                        tree_ready_pulse;

  // Rotating-priority winner among current requests, as index and one-hot
  always_comb begin
    pick_s    = rr_pick(RR_MAX'(req), last_r, (RR_IDX_W+1)'(nreq));
    pick_oh_s = '0;
    for (int i = 0; i < nreq; i++) begin
      pick_oh_s[i] = (pick_s == RR_IDX_W'(i));
    end
  end

  // Operand mux steered by the registered grant, stable LAUNCH..ready_pulse
  always_comb begin
    tree_parts_s = '0;
    for (int i = 0; i < nreq; i++) begin
      tree_parts_s = tree_parts_s | (v_parts_in[i] & {(ngates*F_NBITS){grant_r[i]}});
    end
  end

  verifier_adder_tree #(
    .ngates (ngates)
  ) u_tree (
    .clk         (clk),
    .rstb        (rstb),
    .en          (en_r),
    .v_parts     (tree_parts_s),
    .v           (tree_v),
    .ready       (tree_ready),
    .ready_pulse (tree_ready_pulse)
  );

  // Next-state and next-output decode for the scheduler FSM
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    done_s  = '0;
    v_out_s = v_out_r;
    busy_s  = busy_r;
    en_s    = 1'b0;
    last_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if ((req != '0) && tree_ready) begin
          grant_s = pick_oh_s;
          last_s  = pick_s;
          en_s    = 1'b1;
          busy_s  = 1'b1;
          state_s = ST_LAUNCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (tree_ready_pulse) begin
          v_out_s = tree_v;
          done_s  = grant_r;
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        grant_s = '0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = '0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      done_r  <= '0;
      v_out_r <= '0;
      busy_r  <= 1'b0;
      en_r    <= 1'b0;
      last_r  <= RR_IDX_W'(nreq - 1);
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      done_r  <= done_s;
      v_out_r <= v_out_s;
      busy_r  <= busy_s;
      en_r    <= en_s;
      last_r  <= last_s;
    end
  end

  assign grant = grant_r;
  assign done  = done_r;
  assign v_out = v_out_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_verifier_adder_tree_sched.sv
// Self-checking bench: transaction-level reference model (mod-p sums with
// wide integer arithmetic, round-robin over a requester index).
module tb_verifier_adder_tree_sched;
  import verifier_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int NG   = 35;
  localparam logic [127:0] P128 = 128'(F_PRIME);

  logic                                   clk = 1'b0;
  logic                                   rstb = 1'b0;
  logic [NREQ-1:0]                        req = '0;
  logic [NREQ-1:0][NG-1:0][F_NBITS-1:0]   vparts = '0;
  logic [NREQ-1:0]                        grant;
  logic [NREQ-1:0]                        done;
  logic [F_NBITS-1:0]                     v_out;
  logic                                   busy;

  int n_tests = 0;
  int n_fail  = 0;
  int model_last = NREQ - 1;
  int onehot_err = 0;

  verifier_adder_tree_sched #(.ngates(NG), .nreq(NREQ)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req        (req),
    .v_parts_in (vparts),
    .grant      (grant),
    .done       (done),
    .v_out      (v_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // grant and done must never have more than one bit set
  always @(negedge clk) begin
    if (rstb && (!$onehot0(grant) || !$onehot0(done))) onehot_err++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [F_NBITS-1:0] rand_fe();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return F_NBITS'(x % 64'(F_PRIME));
  endfunction

  function automatic logic [F_NBITS-1:0] model_sum(input int r);
    logic [127:0] acc;
    acc = '0;
    for (int i = 0; i < NG; i++) acc = acc + 128'(vparts[r][i]);
    return F_NBITS'(acc % P128);
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic randomize_parts();
    for (int r = 0; r < NREQ; r++)
      for (int i = 0; i < NG; i++) vparts[r][i] = rand_fe();
  endtask

  // Wait (bounded) for a done pulse, then check winner, grant and sum
  task automatic expect_txn(input string tag, input int exp_idx);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (done != '0) seen = 1'b1;
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd1 << exp_idx);
    chk({tag, "_grant"}, 64'(grant), 64'd1 << exp_idx);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_sum"}, 64'(v_out), 64'(model_sum(exp_idx)));
    model_last = exp_idx;
  endtask

  task automatic wait_grant();
    for (int c = 0; c < 20 && grant == '0; c++) cyc(1);
    chk("wait_grant", 64'(grant != '0), 64'd1);
  endtask

  initial begin
    int w;
    logic [NREQ-1:0] r;
    logic done_seen;

    // Reset state
    cyc(3);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_vout", 64'(v_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rstb = 1'b1;
    cyc(2);

    // Single request with operands 0..34: sum 595
    for (int i = 0; i < NG; i++) vparts[0][i] = F_NBITS'(i);
    req = 4'b0001;
    cyc(1);
    cyc(1);
    chk("single_grant_t1", 64'(grant), 64'd1);
    chk("single_busy_t1", 64'(busy), 64'd1);
    expect_txn("single", model_pick(req));
    chk("single_595", 64'(v_out), 64'd595);
    req = '0;
    cyc(1);
    chk("single_busy_after", 64'(busy), 64'd0);
    chk("single_grant_after", 64'(grant), 64'd0);
    cyc(3);
    chk("single_vout_hold", 64'(v_out), 64'd595);

    // All requesting from reset: 0,1,2,3,0; first arbitration on first rstb=1 cycle
    randomize_parts();
    rstb = 1'b0;
    req  = 4'b1111;
    cyc(2);
    rstb = 1'b1;
    model_last = NREQ - 1;
    cyc(1);
    cyc(1);
    chk("all_first_grant", 64'(grant), 64'd1);
    for (int k = 0; k < 5; k++) begin
      w = model_pick(req);
      expect_txn($sformatf("all_%0d", k), w);
    end

    // Wrap priority: winner 3 then 0101 -> 0 then 2
    req = 4'b1000;
    expect_txn("wrap_w3", model_pick(req));
    req = 4'b0101;
    expect_txn("wrap_a", model_pick(req));
    chk("wrap_a_is0", 64'(model_last), 64'd0);
    expect_txn("wrap_b", model_pick(req));
    chk("wrap_b_is2", 64'(model_last), 64'd2);

    // Random request patterns and operands
    for (int k = 0; k < 20; k++) begin
      randomize_parts();
      r = NREQ'($urandom_range(1, 15));
      req = r;
      expect_txn($sformatf("rnd_%0d", k), model_pick(r));
    end
    req = '0;
    cyc(2);

    // Withdrawn request two cycles into WAIT still completes
    randomize_parts();
    req = 4'b0010;
    w = model_pick(req);
    wait_grant();
    cyc(3);
    req = '0;
    expect_txn("withdraw", w);
    cyc(2);

    // Reset mid-WAIT: no done, outputs cleared, next request works
    req = 4'b0001;
    wait_grant();
    cyc(5);
    rstb = 1'b0;
    req  = '0;
    cyc(1);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_vout", 64'(v_out), 64'd0);
    rstb = 1'b1;
    model_last = NREQ - 1;
    done_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      cyc(1);
      if (done != '0) done_seen = 1'b1;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    req = 4'b0001;
    expect_txn("midrst_after", model_pick(req));
    req = '0;
    cyc(2);

    // Field wrap: every operand p-1 -> p-35
    for (int q = 0; q < NREQ; q++)
      for (int i = 0; i < NG; i++) vparts[q][i] = F_PRIME - F_NBITS'(1);
    req = 4'b0100;
    expect_txn("fwrap", model_pick(req));
    chk("fwrap_const", 64'(v_out), 64'(F_PRIME - F_NBITS'(35)));
    req = '0;
    cyc(2);

    chk("onehot", 64'(onehot_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
